// File: rtl/grb_pkg.sv
// Shared definitions for the GRB multi-block latch.
//   GRB_DATA_W   default width of one GRB word
//   grb_state_t  control FSM states
//   clog2_min1() channel-index width, never less than 1 bit
package grb_pkg;

  localparam int GRB_DATA_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PRESENT = 2'd2
  } grb_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ok_pulse_gen.sv
// Generates the d_ok strobe for one published frame.
//   clk, rst  system clock, async active-high reset
//   start     publish edge: raise d_ok on the next edge
//   d_ack     consumer ack (used only when HANDSHAKE != 0)
//   d_ok      frame-valid output
//   done      high in the last d_ok cycle; d_ok falls on the coming edge
module ok_pulse_gen
  import grb_pkg::*;
#(
  parameter int OK_CYCLES = 2,
  parameter int HANDSHAKE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic d_ack,
  output logic d_ok,
  output logic done
);

  localparam int CNT_W = clog2_min1(OK_CYCLES);

  logic [CNT_W-1:0] cnt;

  // Pulse mode ends after OK_CYCLES high cycles; handshake mode ends on an
  // ack sampled while d_ok is high (an ack with d_ok low is meaningless).
  assign done = d_ok && ((HANDSHAKE != 0) ? d_ack : (cnt == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_ok <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      d_ok <= 1'b1;
      cnt  <= CNT_W'(OK_CYCLES - 1);
    end else if (done) begin
      d_ok <= 1'b0;
    end else if (d_ok && (HANDSHAKE == 0)) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/grb_multi_block_latch.sv
// Collects one GRB word per LED block channel into a shadow bank and
// publishes the full (or flushed partial) frame through a double-buffered
// output bank to the per-block LED serialisers.
//   clk, rst     system clock, async active-high reset
//   GRBdata      word to capture
//   data_rd      capture strobe, one word per cycle
//   ch_idx       target channel of GRBdata (out-of-range indices ignored)
//   flush        publish the partial frame (COLLECT with a non-empty mask)
//   d_ack        consumer ack, HANDSHAKE=1 only
//   chosen_data  published frame, channel 0 in the LSBs
//   ch_valid     channels present in the published frame
//   d_ok         published frame valid
//   busy         high while in PRESENT
//   overrun      1-cycle pulse: a channel was rewritten before publish
// Handshake: d_ok rises on publish. HANDSHAKE=0 holds it OK_CYCLES cycles;
// HANDSHAKE=1 holds it until d_ack is sampled high while d_ok is high. d_ok
// is always low for at least one cycle between frames.
module grb_multi_block_latch
  import grb_pkg::*;
#(
  parameter  int DATA_W    = GRB_DATA_W,
  parameter  int NUM_CH    = 4,
  parameter  int OK_CYCLES = 2,
  parameter  int HANDSHAKE = 0,
  localparam int CH_W      = clog2_min1(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        GRBdata,
  input  logic                     data_rd,
  input  logic [CH_W-1:0]          ch_idx,
  input  logic                     flush,
  input  logic                     d_ack,
  output logic [NUM_CH*DATA_W-1:0] chosen_data,
  output logic [NUM_CH-1:0]        ch_valid,
  output logic                     d_ok,
  output logic                     busy,
  output logic                     overrun
);

  // One bit per encodable index, set where the index names a real channel.
  localparam int IDX_N = 2 ** CH_W;
  localparam logic [IDX_N-1:0] IN_RANGE = {IDX_N{1'b1}} >> (IDX_N - NUM_CH);

  grb_state_t        state, state_nx;
  logic [DATA_W-1:0] shadow [NUM_CH];
  logic [NUM_CH-1:0] mask, mask_nx, wr_onehot;
  logic              cap, publish, overrun_nx, ok_done;

  assign cap       = (state != ST_IDLE) && data_rd && IN_RANGE[ch_idx];
  assign wr_onehot = cap ? (NUM_CH'(1) << ch_idx) : '0;
  assign publish   = (state == ST_COLLECT) && ((&mask) || (flush && (|mask)));

  // A word captured in the publish cycle starts the next frame, so it never
  // counts as a rewrite of the frame being published.
  assign overrun_nx = cap && !publish && (|(mask & wr_onehot));
  assign mask_nx    = publish ? wr_onehot : (mask | wr_onehot);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    state_nx = ST_COLLECT;
      ST_COLLECT: if (publish) state_nx = ST_PRESENT;
      ST_PRESENT: if (ok_done) state_nx = ST_COLLECT;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      mask        <= '0;
      chosen_data <= '0;
      ch_valid    <= '0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
    end else begin
      state   <= state_nx;
      mask    <= mask_nx;
      busy    <= (state_nx == ST_PRESENT);
      overrun <= overrun_nx;
      if (cap) shadow[ch_idx] <= GRBdata;
      // Output bank takes the pre-edge shadow contents.
      if (publish) begin
        ch_valid <= mask;
        for (int i = 0; i < NUM_CH; i++)
          chosen_data[i*DATA_W +: DATA_W] <= mask[i] ? shadow[i] : '0;
      end
    end
  end

  ok_pulse_gen #(
    .OK_CYCLES (OK_CYCLES),
    .HANDSHAKE (HANDSHAKE)
  ) u_ok (
    .clk   (clk),
    .rst   (rst),
    .start (publish),
    .d_ack (d_ack),
    .d_ok  (d_ok),
    .done  (ok_done)
  );

endmodule
